// File: rtl/param_stream_demux_reg.sv
// param_stream_demux_reg
// Registered 1-to-N stream demultiplexer. Each output channel owns one
// holding slot with its own valid/ready handshake, so consumers can stall
// independently. A broadcast word loads every slot at once. A unicast word
// whose select names no existing channel is swallowed and raises a sticky
// sel_err flag.
module param_stream_demux_reg #(
   parameter int WIDTH   = 8,
   parameter int NUM_OUT = 4,
   parameter int SEL_W   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic                     in_bcast,
   output logic [NUM_OUT-1:0]       out_valid,
   input  logic [NUM_OUT-1:0]       out_ready,
   output logic [NUM_OUT*WIDTH-1:0] out_data,
   output logic                     sel_err
);

   logic [NUM_OUT-1:0] slot_valid_q, slot_valid_d;
   logic [WIDTH-1:0]   slot_data_q [NUM_OUT];
   logic [WIDTH-1:0]   slot_data_d [NUM_OUT];
   logic               sel_err_q, sel_err_d;

   logic [NUM_OUT-1:0] drain;
   logic [NUM_OUT-1:0] free;
   logic [NUM_OUT-1:0] load;
   logic               sel_in_range;
   logic               accept;

   // Slot occupancy: a slot is free if empty or being drained this cycle,
   // which lets a stalled-then-released consumer accept back-to-back words.
   always_comb begin
      drain = slot_valid_q & out_ready;
      free  = ~slot_valid_q | drain;
   end

   // Compare in one extra bit so NUM_OUT == 2**SEL_W does not wrap to zero.
   always_comb begin
      sel_in_range = ({1'b0, in_sel} < (SEL_W+1)'(NUM_OUT));
   end

   // Producer readiness; deliberately independent of in_valid.
   always_comb begin
      in_ready = 1'b1;
      if (in_bcast) begin
         in_ready = &free;
      end else if (sel_in_range) begin
         for (int k = 0; k < NUM_OUT; k++) begin
            if (in_sel == SEL_W'(k)) begin
               in_ready = free[k];
            end
         end
      end
   end

   // Which slots take the incoming word; an out-of-range select matches none.
   always_comb begin
      accept = in_valid & in_ready;
      load   = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         load[k] = accept & (in_bcast | (in_sel == SEL_W'(k)));
      end
   end

   // Next slot state: load has priority over drain on the same slot.
   always_comb begin
      slot_valid_d = slot_valid_q;
      for (int k = 0; k < NUM_OUT; k++) begin
         slot_valid_d[k] = load[k] | (slot_valid_q[k] & ~drain[k]);
         slot_data_d[k]  = load[k] ? in_data : slot_data_q[k];
      end
   end

   // Sticky error: a discarded unicast word with a nonexistent target.
   always_comb begin
      sel_err_d = sel_err_q | (accept & ~in_bcast & ~sel_in_range);
   end

   // State registers; reset empties every slot and clears the error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_valid_q <= '0;
         sel_err_q    <= 1'b0;
         for (int k = 0; k < NUM_OUT; k++) begin
            slot_data_q[k] <= '0;
         end
      end else begin
         slot_valid_q <= slot_valid_d;
         sel_err_q    <= sel_err_d;
         for (int k = 0; k < NUM_OUT; k++) begin
            slot_data_q[k] <= slot_data_d[k];
         end
      end
   end

   // Outputs come straight from the slot registers.
   always_comb begin
      out_valid = slot_valid_q;
      sel_err   = sel_err_q;
      out_data  = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         out_data[k*WIDTH +: WIDTH] = slot_data_q[k];
      end
   end

endmodule

// File: tb/tb_param_stream_demux_reg.sv
// Scoreboard bench: stimulus pushes expected words per channel, a monitor
// pops and compares on every observed drain. A second instance with three
// channels exercises the out-of-range select.
module tb_param_stream_demux_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_bcast;
   logic [7:0]  in_data;
   logic [1:0]  in_sel;
   logic [3:0]  out_valid, out_ready;
   logic [31:0] out_data;
   logic        sel_err;

   logic        in_valid3, in_ready3, in_bcast3;
   logic [7:0]  in_data3;
   logic [1:0]  in_sel3;
   logic [2:0]  out_valid3, out_ready3;
   logic [23:0] out_data3;
   logic        sel_err3;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q [4][$];
   int pop_cnt [4];

   always #5 clk = ~clk;

   param_stream_demux_reg #(.WIDTH(8), .NUM_OUT(4), .SEL_W(2)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sel_err(sel_err));

   param_stream_demux_reg #(.WIDTH(8), .NUM_OUT(3), .SEL_W(2)) dut3 (
      .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_data(in_data3), .in_sel(in_sel3), .in_bcast(in_bcast3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
      .sel_err(sel_err3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic [1:0] s, input logic b);
      if (b) begin
         for (int k = 0; k < 4; k++) exp_q[k].push_back(d);
      end else begin
         exp_q[s].push_back(d);
      end
   endtask

   task automatic clear_q();
      for (int k = 0; k < 4; k++) exp_q[k].delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one word that the bench expects to be accepted immediately.
   task automatic send(input logic [7:0] d, input logic [1:0] s, input logic b);
      in_valid = 1'b1;
      in_data  = d;
      in_sel   = s;
      in_bcast = b;
      @(negedge clk);
      chk("send_in_ready", 32'(in_ready), 32'd1);
      if (in_ready) push(d, s, b);
      tick();
      in_valid = 1'b0;
   endtask

   // Monitor: every drain must match the oldest expected word of its channel.
   always @(negedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 4; k++) begin
            if (out_valid[k] && out_ready[k]) begin
               checks++;
               if (exp_q[k].size() == 0) begin
                  errors++;
                  $display("FAIL drain_ch%0d: got word %h, required no word", k, out_data[k*8 +: 8]);
               end else begin
                  logic [7:0] e;
                  e = exp_q[k].pop_front();
                  pop_cnt[k]++;
                  if (out_data[k*8 +: 8] !== e) begin
                     errors++;
                     $display("FAIL drain_ch%0d: got %h, required %h", k, out_data[k*8 +: 8], e);
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base0, base1;
      logic [7:0] w;
      for (int k = 0; k < 4; k++) pop_cnt[k] = 0;
      reset = 1'b1;
      in_valid = 0; in_data = 0; in_sel = 0; in_bcast = 0; out_ready = 4'b0000;
      in_valid3 = 0; in_data3 = 0; in_sel3 = 0; in_bcast3 = 0; out_ready3 = 3'b111;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("post_reset_in_ready", 32'(in_ready), 32'd1);

      // 1: reset with slots 1 and 3 full, checked before any clock edge
      send(8'h55, 2'd1, 1'b0);
      send(8'h77, 2'd3, 1'b0);
      chk("fill_1_3_valid", 32'(out_valid), 32'b1010);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_data", out_data, 32'd0);
      chk("async_rst_sel_err", 32'(sel_err), 32'd0);
      clear_q();
      tick();
      reset = 1'b0;
      chk("rst_release_in_ready", 32'(in_ready), 32'd1);
      out_ready = 4'b1111;

      // 2: unicast to each channel, one-cycle latency, then drained
      begin
         logic [1:0] sels [4];
         sels[0] = 2'd2; sels[1] = 2'd0; sels[2] = 2'd1; sels[3] = 2'd3;
         for (int i = 0; i < 4; i++) begin
            send(8'hA5, sels[i], 1'b0);
            chk("uni_valid", 32'(out_valid), 32'(4'b0001 << sels[i]));
            chk("uni_data", 32'(out_data[sels[i]*8 +: 8]), 32'hA5);
            tick();
            chk("uni_empty", 32'(out_valid), 32'd0);
         end
      end

      // 3: back-pressure on channel 1
      out_ready = 4'b1101;
      send(8'h11, 2'd1, 1'b0);
      chk("bp_fill_valid", 32'(out_valid), 32'b0010);
      in_valid = 1'b1; in_data = 8'h22; in_sel = 2'd1; in_bcast = 1'b0;
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_hold_a", 32'(out_data[15:8]), 32'h11);
      tick();
      chk("bp_hold_b", 32'(out_data[15:8]), 32'h11);
      out_ready = 4'b1111;
      @(negedge clk);
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      if (in_ready) push(8'h22, 2'd1, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("bp_new_valid", 32'(out_valid), 32'b0010);
      chk("bp_new_data", 32'(out_data[15:8]), 32'h22);
      tick();

      // 4: broadcast blocked by a stalled slot 0
      out_ready = 4'b1110;
      send(8'h01, 2'd0, 1'b0);
      in_valid = 1'b1; in_data = 8'h3C; in_sel = 2'd2; in_bcast = 1'b1;
      @(negedge clk);
      chk("bc_in_ready_low", 32'(in_ready), 32'd0);
      tick();
      out_ready = 4'b1111;
      @(negedge clk);
      chk("bc_in_ready_high", 32'(in_ready), 32'd1);
      if (in_ready) push(8'h3C, 2'd0, 1'b1);
      tick();
      in_valid = 1'b0;
      in_bcast = 1'b0;
      chk("bc_valid", 32'(out_valid), 32'b1111);
      chk("bc_data", out_data, 32'h3C3C3C3C);
      tick();

      // 5: streaming, 100 words per channel alternating 0/1
      base0 = pop_cnt[0];
      base1 = pop_cnt[1];
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         w = 8'(i * 7 + 3);
         in_data = w;
         in_sel  = 2'(i % 2);
         @(negedge clk);
         chk("stream_in_ready", 32'(in_ready), 32'd1);
         if (in_ready) push(w, 2'(i % 2), 1'b0);
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();
      chk("stream_ch0_count", 32'(pop_cnt[0] - base0), 32'd100);
      chk("stream_ch1_count", 32'(pop_cnt[1] - base1), 32'd100);
      for (int k = 0; k < 4; k++) chk("queue_empty", 32'(exp_q[k].size()), 32'd0);
      chk("main_sel_err", 32'(sel_err), 32'd0);

      // 6: out-of-range select on the three-channel instance
      in_valid3 = 1'b1; in_data3 = 8'hFF; in_sel3 = 2'd3; in_bcast3 = 1'b0;
      @(negedge clk);
      chk("oor_in_ready", 32'(in_ready3), 32'd1);
      tick();
      in_valid3 = 1'b0;
      chk("oor_no_valid", 32'(out_valid3), 32'd0);
      chk("oor_sel_err", 32'(sel_err3), 32'd1);
      tick();
      chk("oor_sticky_a", 32'(sel_err3), 32'd1);
      out_ready3 = 3'b000;
      in_valid3 = 1'b1; in_data3 = 8'h5A; in_sel3 = 2'd2;
      @(negedge clk);
      chk("n3_in_ready", 32'(in_ready3), 32'd1);
      tick();
      in_valid3 = 1'b0;
      chk("n3_valid", 32'(out_valid3), 32'b100);
      chk("n3_data", 32'(out_data3[23:16]), 32'h5A);
      chk("oor_sticky_b", 32'(sel_err3), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("oor_rst_sel_err", 32'(sel_err3), 32'd0);
      chk("n3_rst_valid", 32'(out_valid3), 32'd0);
      clear_q();
      tick();
      reset = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
